// File: rtl/a2d_scan_sched.sv
// a2d_scan_sched
// Conversion scheduler for the A2D SPI interface. A period timer starts a
// scan of the channels enabled in i_ch_mask. Each scan walks the enabled
// channels in ascending order and issues one conversion at a time over the
// strt_cnv / chnnl / cnv_cmplt handshake. A one-shot request port has
// priority over the scan. Completed results are stored in an 8-entry result
// file that is read combinationally.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_en              enable periodic scanning
//   i_ch_mask         channels included in a scan (latched at scan start)
//   o_strt_cnv        one-cycle conversion start
//   o_chnnl           channel of the current / last conversion
//   i_cnv_cmplt       conversion complete (ignored outside CONV)
//   i_res             conversion result
//   i_req             one-shot request, held until o_req_ack
//   i_req_chnnl       requested channel
//   o_req_ack         one-cycle pulse: request conversion started
//   o_req_vld         one-cycle pulse: o_req_res valid
//   o_req_res         result of the last request conversion
//   i_rd_chnnl        result file read address
//   o_rd_res          stored result for i_rd_chnnl
//   o_res_vld         per-channel sticky "written since reset"
//   o_scan_done       one-cycle pulse: scan finished
//   o_busy            conversion in flight
//   o_overrun         sticky: scan tick dropped (cleared by reset or en=0)
//   o_tmo_err         one-cycle pulse: conversion abandoned on timeout
module a2d_scan_sched #(
    parameter int SCAN_PERIOD = 4096,
    parameter int TIMEOUT     = 65535
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [7:0]  i_ch_mask,
    output logic        o_strt_cnv,
    output logic [2:0]  o_chnnl,
    input  logic        i_cnv_cmplt,
    input  logic [11:0] i_res,
    input  logic        i_req,
    input  logic [2:0]  i_req_chnnl,
    output logic        o_req_ack,
    output logic        o_req_vld,
    output logic [11:0] o_req_res,
    input  logic [2:0]  i_rd_chnnl,
    output logic [11:0] o_rd_res,
    output logic [7:0]  o_res_vld,
    output logic        o_scan_done,
    output logic        o_busy,
    output logic        o_overrun,
    output logic        o_tmo_err
);

    localparam int PW = $clog2(SCAN_PERIOD);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [PW-1:0] r_tmr;
    logic [TW-1:0] r_wdog;
    logic          r_scan_act;
    // Channels of the current scan not yet converted; the lowest set bit is
    // the scan pointer.
    logic [7:0]    r_rem;
    logic          r_overrun;
    logic          r_is_req;
    logic          r_strt;
    logic [2:0]    r_chnnl;
    logic          r_req_ack;
    logic          r_req_vld;
    logic [11:0]   r_req_res;
    logic [11:0]   r_file [8];
    logic [7:0]    r_res_vld;
    logic          r_scan_done;
    logic          r_tmo;

    logic          w_tick;
    logic          w_scan_ok;
    logic          w_has_ch;
    logic [2:0]    w_nxt_ch;
    logic          w_start;
    logic          w_start_req;
    logic [2:0]    w_start_ch;
    logic          w_scan_fin;
    logic          w_cmplt;
    logic          w_tmo;
    logic          w_conv_end;
    logic          w_scan_load;

    assign w_tick      = i_en && (r_tmr == PW'(SCAN_PERIOD - 1));
    // Scan starts are gated by i_en so a falling en never launches another
    // scan channel, even in the cycle before scan_act clears.
    assign w_scan_ok   = r_scan_act && i_en;
    assign w_has_ch    = |r_rem;
    assign w_scan_load = w_tick && !r_scan_act;
    assign w_conv_end  = w_cmplt || w_tmo;

    always_comb begin
        w_nxt_ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_rem[i]) w_nxt_ch = 3'(i);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_start_req = 1'b0;
        w_start_ch  = r_chnnl;
        w_scan_fin  = 1'b0;
        w_cmplt     = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req) begin
                    w_start     = 1'b1;
                    w_start_req = 1'b1;
                    w_start_ch  = i_req_chnnl;
                    w_state_nxt = S_CONV;
                end else if (w_scan_ok && w_has_ch) begin
                    w_start     = 1'b1;
                    w_start_ch  = w_nxt_ch;
                    w_state_nxt = S_CONV;
                end else if (w_scan_ok) begin
                    w_scan_fin  = 1'b1;
                end
            end
            S_CONV: begin
                // Watchdog is 0 in the strt_cnv cycle, so the abandon
                // decision lands TIMEOUT-1 cycles later and tmo_err appears
                // TIMEOUT cycles after strt_cnv.
                if (i_cnv_cmplt) begin
                    w_cmplt     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_wdog == TW'(TIMEOUT - 1)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tmr       <= '0;
            r_wdog      <= '0;
            r_scan_act  <= 1'b0;
            r_rem       <= '0;
            r_overrun   <= 1'b0;
            r_is_req    <= 1'b0;
            r_strt      <= 1'b0;
            r_chnnl     <= 3'd0;
            r_req_ack   <= 1'b0;
            r_req_vld   <= 1'b0;
            r_req_res   <= '0;
            r_res_vld   <= '0;
            r_scan_done <= 1'b0;
            r_tmo       <= 1'b0;
            for (int i = 0; i < 8; i++) r_file[i] <= '0;
        end else begin
            r_strt      <= w_start;
            r_req_ack   <= w_start_req;
            r_scan_done <= w_scan_fin;
            r_tmo       <= w_tmo;
            r_req_vld   <= w_cmplt && r_is_req;

            if (w_start) begin
                r_chnnl  <= w_start_ch;
                r_is_req <= w_start_req;
                r_wdog   <= '0;
            end else if (r_state == S_CONV) begin
                r_wdog   <= r_wdog + TW'(1);
            end

            if (w_cmplt) begin
                r_file[r_chnnl]    <= i_res;
                r_res_vld[r_chnnl] <= 1'b1;
                if (r_is_req) r_req_res <= i_res;
            end

            if (!i_en || w_tick) r_tmr <= '0;
            else                 r_tmr <= r_tmr + PW'(1);

            // Tick and completion in the same cycle both take effect; the
            // tick tests the pre-cycle scan_act.
            if (!i_en)            r_scan_act <= 1'b0;
            else if (w_scan_load) r_scan_act <= 1'b1;
            else if (w_scan_fin)  r_scan_act <= 1'b0;

            if (w_scan_load)                  r_rem          <= i_ch_mask;
            else if (w_conv_end && !r_is_req) r_rem[r_chnnl] <= 1'b0;

            if (!i_en)                      r_overrun <= 1'b0;
            else if (w_tick && r_scan_act)  r_overrun <= 1'b1;
        end
    end

    assign o_strt_cnv  = r_strt;
    assign o_chnnl     = r_chnnl;
    assign o_req_ack   = r_req_ack;
    assign o_req_vld   = r_req_vld;
    assign o_req_res   = r_req_res;
    assign o_rd_res    = r_file[i_rd_chnnl];
    assign o_res_vld   = r_res_vld;
    assign o_scan_done = r_scan_done;
    assign o_busy      = (r_state == S_CONV);
    assign o_overrun   = r_overrun;
    assign o_tmo_err   = r_tmo;

endmodule

// File: tb/tb_a2d_scan_sched.sv
// tb_a2d_scan_sched
// Randomized self-checking bench for a2d_scan_sched. An A2D responder model
// answers strt_cnv after a programmable latency (or never), and a monitor
// logs starts, scan_done, tmo_err and req_vld events. Expected channel
// sequences come from the scan mask (ascending set bits), expected stored
// results from the values the responder delivered.
module tb_a2d_scan_sched;

    localparam int SP = 64;
    localparam int TO = 32;

    logic        clk = 1'b0;
    logic        rst, en, cnv_cmplt, req;
    logic [7:0]  ch_mask;
    logic [11:0] res;
    logic [2:0]  req_chnnl, rd_chnnl;
    logic        strt_cnv, req_ack, req_vld, scan_done, busy, overrun, tmo_err;
    logic [2:0]  chnnl;
    logic [11:0] req_res, rd_res;
    logic [7:0]  res_vld;

    a2d_scan_sched #(.SCAN_PERIOD(SP), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_ch_mask(ch_mask),
        .o_strt_cnv(strt_cnv), .o_chnnl(chnnl), .i_cnv_cmplt(cnv_cmplt),
        .i_res(res), .i_req(req), .i_req_chnnl(req_chnnl), .o_req_ack(req_ack),
        .o_req_vld(req_vld), .o_req_res(req_res), .i_rd_chnnl(rd_chnnl),
        .o_rd_res(rd_res), .o_res_vld(res_vld), .o_scan_done(scan_done),
        .o_busy(busy), .o_overrun(overrun), .o_tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // responder / monitor state
    int          lat = 10;
    bit          hang = 0;
    logic [11:0] res_base = 12'h100;
    int          cnt = 0;
    logic [2:0]  cur_ch = 3'd0;
    bit          cur_req = 0, cur_live = 0, prev_strt = 0;
    logic [11:0] exp_file [8];
    int          st_ch[$], st_req[$], st_cyc[$], tmo_cyc[$];
    int          cyc = 0, done_cnt = 0, rv_cnt = 0, ack_cnt = 0;
    logic [11:0] rv_res = '0;

    always @(negedge clk) begin
        cyc++;
        cnv_cmplt = 1'b0;
        if (strt_cnv) begin
            chk("strt_gap", 32'(prev_strt), 0);
            st_ch.push_back(int'(chnnl));
            st_req.push_back(int'(req_ack));
            st_cyc.push_back(cyc);
            cur_ch = chnnl; cur_req = req_ack; cur_live = 1;
            cnt = hang ? 0 : lat;
            if (req_ack) ack_cnt++;
        end else begin
            if (req_ack) chk("ack_wo_strt", 32'(strt_cnv), 1);
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    cnv_cmplt = 1'b1;
                    res = res_base + 12'(cur_ch);
                    if (cur_live) exp_file[cur_ch] = res;
                    cur_live = 0;
                end
            end
        end
        if (scan_done) done_cnt++;
        if (tmo_err) tmo_cyc.push_back(cyc);
        if (req_vld) begin rv_cnt++; rv_res = req_res; end
        prev_strt = strt_cnv;
    end

    task automatic chk_file(input string tag);
        for (int c = 0; c < 8; c++) begin
            rd_chnnl = 3'(c);
            #1;
            chk($sformatf("%s_rd%0d", tag, c), 32'(rd_res), 32'(exp_file[c]));
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_strt"}, 32'(strt_cnv), 0);
        chk({tag, "_chnnl"}, 32'(chnnl), 0);
        chk({tag, "_ack"}, 32'(req_ack), 0);
        chk({tag, "_rvld"}, 32'(req_vld), 0);
        chk({tag, "_rres"}, 32'(req_res), 0);
        chk({tag, "_resvld"}, 32'(res_vld), 0);
        chk({tag, "_done"}, 32'(scan_done), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ovr"}, 32'(overrun), 0);
        chk({tag, "_tmo"}, 32'(tmo_err), 0);
        chk_file(tag);
    endtask

    task automatic do_rst(input string tag);
        @(negedge clk);
        rst = 1'b1; en = 1'b0; req = 1'b0;
        cur_live = 0;
        for (int c = 0; c < 8; c++) exp_file[c] = '0;
        st_ch.delete(); st_req.delete(); st_cyc.delete(); tmo_cyc.delete();
        done_cnt = 0; rv_cnt = 0; ack_cnt = 0;
        @(negedge clk);
        chk_rst(tag);
        rst = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n, input int maxc);
        int k = 0;
        while (done_cnt < n && k < maxc) begin @(negedge clk); k++; end
        chk({tag, "_done_wait"}, 32'(done_cnt >= n), 1);
    endtask

    task automatic wait_starts(input string tag, input int n, input int maxc);
        int k = 0;
        while (st_ch.size() < n && k < maxc) begin @(negedge clk); k++; end
        chk({tag, "_strt_wait"}, 32'(st_ch.size() >= n), 1);
    endtask

    task automatic do_req(input string tag, input logic [2:0] c);
        int k = 0;
        int a0 = ack_cnt;
        req = 1'b1; req_chnnl = c;
        while (ack_cnt == a0 && k < 300) begin @(negedge clk); k++; end
        chk({tag, "_ack_wait"}, 32'(ack_cnt > a0), 1);
        req = 1'b0;
    endtask

    // Expected scan order: ascending set bits of the mask, none via request.
    task automatic chk_seq(input string tag, input logic [7:0] m);
        int exp_q[$];
        for (int c = 0; c < 8; c++) if (m[c]) exp_q.push_back(c);
        chk({tag, "_nstrt"}, 32'(st_ch.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < st_ch.size(); i++) begin
            chk($sformatf("%s_ch%0d", tag, i), 32'(st_ch[i]), 32'(exp_q[i]));
            chk($sformatf("%s_req%0d", tag, i), 32'(st_req[i]), 0);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; ch_mask = '0; cnv_cmplt = 1'b0; res = '0;
        req = 1'b0; req_chnnl = '0; rd_chnnl = '0;

        do_rst("rst0");

        // basic scan of channels 0, 2, 7
        ch_mask = 8'h85; en = 1'b1;
        wait_done("p1", 1, 300);
        en = 1'b0;
        chk_seq("p1", 8'h85);
        rd_chnnl = 3'd2; #1;
        chk("p1_rd2", 32'(rd_res), 32'h102);
        chk("p1_vld", 32'(res_vld), 32'h85);
        chk("p1_ndone", 32'(done_cnt), 1);
        chk("p1_ovr", 32'(overrun), 0);
        chk_file("p1");

        // request for channel 5 raised while channel 2 is converting
        do_rst("rst1");
        ch_mask = 8'h85; en = 1'b1;
        wait_starts("p2", 2, 300);
        do_req("p2", 3'd5);
        wait_done("p2", 1, 300);
        en = 1'b0;
        chk("p2_nstrt", 32'(st_ch.size()), 4);
        if (st_ch.size() == 4) begin
            chk("p2_ch0", 32'(st_ch[0]), 0);
            chk("p2_ch1", 32'(st_ch[1]), 2);
            chk("p2_ch2", 32'(st_ch[2]), 5);
            chk("p2_ch3", 32'(st_ch[3]), 7);
            chk("p2_ack2", 32'(st_req[2]), 1);
            chk("p2_ack3", 32'(st_req[3]), 0);
        end
        chk("p2_nrv", 32'(rv_cnt), 1);
        chk("p2_rvres", 32'(rv_res), 32'h105);
        chk("p2_vld", 32'(res_vld), 32'ha5);

        // randomized masks, latencies and result values; then a request with en=0
        for (int it = 0; it < 4; it++) begin
            logic [7:0] m;
            logic [2:0] rc;
            do_rst($sformatf("rr%0d", it));
            m = 8'($urandom_range(1, 255));
            lat = $urandom_range(1, 4);
            res_base = 12'($urandom);
            ch_mask = m; en = 1'b1;
            wait_done($sformatf("r%0d", it), 1, 400);
            en = 1'b0;
            chk_seq($sformatf("r%0d", it), m);
            chk($sformatf("r%0d_vld", it), 32'(res_vld), 32'(m));
            chk($sformatf("r%0d_ovr", it), 32'(overrun), 0);
            chk_file($sformatf("r%0d", it));
            rc = 3'($urandom_range(0, 7));
            do_req($sformatf("rq%0d", it), rc);
            repeat (lat + 3) @(negedge clk);
            chk($sformatf("rq%0d_nrv", it), 32'(rv_cnt), 1);
            chk($sformatf("rq%0d_res", it), 32'(rv_res), 32'(12'(res_base + 12'(rc))));
            chk($sformatf("rq%0d_vld", it), 32'(res_vld), 32'(m | (8'd1 << rc)));
            chk_file($sformatf("rq%0d", it));
        end
        lat = 10; res_base = 12'h100;

        // A2D never completes: watchdog abandons each conversion
        do_rst("rst2");
        hang = 1;
        ch_mask = 8'h06; en = 1'b1;
        wait_done("t", 1, 400);
        en = 1'b0;
        chk_seq("t", 8'h06);
        chk("t_ntmo", 32'(tmo_cyc.size()), 2);
        if (tmo_cyc.size() >= 2 && st_cyc.size() >= 2) begin
            chk("t_lat0", 32'(tmo_cyc[0] - st_cyc[0]), TO);
            chk("t_lat1", 32'(tmo_cyc[1] - st_cyc[1]), TO);
        end
        chk("t_vld", 32'(res_vld), 0);
        hang = 0;

        // empty mask: scan_done every tick, never a start
        do_rst("rst3");
        ch_mask = 8'h00; en = 1'b1;
        repeat (3 * SP + 10) @(negedge clk);
        chk("z_ndone", 32'(done_cnt), 3);
        chk("z_nstrt", 32'(st_ch.size()), 0);
        en = 1'b0;

        // long conversions: second tick arrives mid-scan
        do_rst("rst4");
        ch_mask = 8'hff; lat = 20; en = 1'b1;
        repeat (SP + 10) @(negedge clk);
        chk("o_ovr_pre", 32'(overrun), 0);
        repeat (SP) @(negedge clk);
        chk("o_ovr", 32'(overrun), 1);
        en = 1'b0;
        @(negedge clk);
        chk("o_ovr_clr", 32'(overrun), 0);
        lat = 10;

        // reset while busy, then the late cnv_cmplt must be ignored
        do_rst("rst5");
        ch_mask = 8'h01; en = 1'b1;
        wait_starts("b", 1, 200);
        repeat (3) @(negedge clk);
        chk("b_busy", 32'(busy), 1);
        do_rst("b_rst");
        repeat (15) @(negedge clk);
        chk("b_vld", 32'(res_vld), 0);
        chk("b_busy2", 32'(busy), 0);
        chk("b_rv", 32'(rv_cnt), 0);
        chk_file("b_late");

        // en dropped mid-scan: in-flight result stored, no scan_done
        do_rst("rst6");
        ch_mask = 8'h85; en = 1'b1;
        wait_starts("e", 1, 200);
        en = 1'b0;
        repeat (30) @(negedge clk);
        chk("e_vld", 32'(res_vld), 32'h01);
        chk("e_ndone", 32'(done_cnt), 0);
        chk("e_nstrt", 32'(st_ch.size()), 1);
        chk_file("e");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1, "bench time limit");
    end

endmodule
